// File: rtl/uart_tx_arbiter.sv
// Round-robin front end for a single UART transmitter: accepts one byte from one of
// NUM_REQ producers, launches the frame, waits for tx_done and recovers via a watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int IDW            = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic                   frame_done,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  // Handshake: a byte moves from requester i when req_valid[i] & req_ready[i] at a rising
  // edge; req_ready is only ever raised in IDLE, for the round-robin winner, for one cycle.

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  idx_w;
  logic            win_found;
  logic [CW-1:0]   wd_cnt;
  logic            wd_expire;
  logic            done_ok;

  // First valid requester strictly after last_grant, wrapping.
  always_comb begin
    int idx;
    winner    = '0;
    win_found = 1'b0;
    idx_w     = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(last_grant) + i) % NUM_REQ;
      idx_w = IDW'(idx);
      if (!win_found && req_valid[idx_w]) begin
        winner    = idx_w;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_found) req_ready[winner] = 1'b1;
  end

  assign done_ok   = (state == WAIT) && tx_done;
  assign wd_expire = (state == WAIT) && !tx_done && (wd_cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (done_ok || wd_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_start    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
      last_grant  <= IDW'(NUM_REQ - 1);
    end else begin
      tx_start   <= (state_nxt == START);
      busy       <= (state_nxt != IDLE);
      frame_done <= done_ok;
      if (state == IDLE && win_found) begin
        tx_data  <= req_data[int'(winner)*8 +: 8];
        grant_id <= winner;
      end
      // Saturating watchdog; cleared while the start pulse is out.
      if (state == START)
        wd_cnt <= '0;
      else if (state == WAIT && !tx_done && wd_cnt != CNT_MAX)
        wd_cnt <= wd_cnt + 1'b1;
      if (done_ok || wd_expire) last_grant <= grant_id;
      if (wd_expire)    timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural 11-cycle UART transmitter model
// and a byte scoreboard fed at each accept and drained at each completed frame.
module tb_uart_tx_arbiter;

  localparam int T_CYC = 32;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        frame_done;
  logic        timeout_err;
  logic        err_clr;

  logic        xmit_done;
  logic        spur_done;
  logic        model_en;
  logic        tx_out;
  logic [7:0]  exp_q[$];
  logic [7:0]  byte_tab[4];
  int          total;
  int          bad;
  int          cyc;

  assign tx_done = xmit_done | spur_done;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(T_CYC)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  // Clock and cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // Transmitter model: start bit one cycle after tx_start, 8 data bits LSB first,
  // stop bit, then tx_done 11 cycles after tx_start. Aborts on reset.
  initial begin
    int         cnt;
    logic [7:0] sh;
    logic [7:0] rx;
    cnt = 0; sh = '0; rx = '0;
    xmit_done = 1'b0;
    tx_out    = 1'b1;
    forever begin
      @(negedge clk);
      xmit_done = 1'b0;
      if (reset !== 1'b1) begin
        cnt = 0;
        tx_out = 1'b1;
      end else if (cnt == 0) begin
        if (tx_start === 1'b1 && model_en) cnt = 1;
      end else begin
        if (cnt == 1) begin
          sh = tx_data;
          tx_out = 1'b0;
        end else if (cnt <= 9) begin
          check("tx_data_hold", {24'd0, tx_data}, {24'd0, sh});
          tx_out = sh[cnt-2];
          rx[cnt-2] = tx_out;
        end else if (cnt == 10) begin
          check("tx_data_hold", {24'd0, tx_data}, {24'd0, sh});
          tx_out = 1'b1;
          if (exp_q.size() == 0) check("unexpected_frame", {24'd0, rx}, 32'hFFFF_FFFF);
          else check("serial_byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
        end else begin
          check("tx_data_hold", {24'd0, tx_data}, {24'd0, sh});
          xmit_done = 1'b1;
        end
        cnt = (cnt == 11) ? 0 : cnt + 1;
      end
    end
  end

  // One accepted byte through to frame_done, with exact cycle expectations.
  task automatic run_frame(input logic [3:0] valid, input int g, input logic [7:0] b,
                           input bit spur_start);
    logic [3:0] one;
    one = 4'b0001 << g;
    wait_idle();
    req_valid = valid;
    #1;
    check("req_ready", {28'd0, req_ready}, {28'd0, one});
    exp_q.push_back(b);
    tick();
    req_valid = 4'b0000;
    check("tx_start", {31'd0, tx_start}, 32'd1);
    check("grant_id", {30'd0, grant_id}, g);
    check("tx_data", {24'd0, tx_data}, {24'd0, b});
    check("busy_start", {31'd0, busy}, 32'd1);
    if (spur_start) spur_done = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      spur_done = 1'b0;
      if (k == 1) check("tx_start_pulse", {31'd0, tx_start}, 32'd0);
      if (k < 12) check("frame_done_early", {31'd0, frame_done}, 32'd0);
      else begin
        check("frame_done", {31'd0, frame_done}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
      end
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    int         grant;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int gid[5];
    int gcyc[5];
    int n;
    total = 0; bad = 0;
    byte_tab[0] = 8'h10; byte_tab[1] = 8'h21; byte_tab[2] = 8'h32; byte_tab[3] = 8'h43;
    vecs[0]  = '{4'b1111, 2};
    vecs[1]  = '{4'b0011, 0};
    vecs[2]  = '{4'b0011, 1};
    vecs[3]  = '{4'b1111, 2};
    vecs[4]  = '{4'b1111, 3};
    vecs[5]  = '{4'b1111, 0};
    vecs[6]  = '{4'b1000, 3};
    vecs[7]  = '{4'b0101, 0};
    vecs[8]  = '{4'b0101, 2};
    vecs[9]  = '{4'b0100, 2};
    vecs[10] = '{4'b1010, 3};
    vecs[11] = '{4'b0110, 1};

    reset = 1'b0; req_valid = 4'b0000; req_data = 32'h4332_2110;
    err_clr = 1'b0; spur_done = 1'b0; model_en = 1'b1;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);

    // Release reset with requester 0 offering 0xA5.
    reset = 1'b1;
    req_data[7:0] = 8'hA5;
    check("post_rst_tx_data", {24'd0, tx_data}, 32'd0);
    run_frame(4'b0001, 0, 8'hA5, 1'b0);
    req_data = 32'h4332_2110;

    // Spurious tx_done in IDLE, then in START.
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    check("spur_idle_busy", {31'd0, busy}, 32'd0);
    check("spur_idle_frame_done", {31'd0, frame_done}, 32'd0);
    run_frame(4'b1111, 1, byte_tab[1], 1'b1);

    for (int v = 0; v < 12; v++)
      run_frame(vecs[v].valid, vecs[v].grant, byte_tab[vecs[v].grant], 1'b0);

    // Watchdog: transmitter silent.
    model_en = 1'b0;
    wait_idle();
    req_valid = 4'b0001;
    #1;
    check("wd_req_ready", {28'd0, req_ready}, 32'd1);
    tick();
    req_valid = 4'b0000;
    check("wd_tx_start", {31'd0, tx_start}, 32'd1);
    for (int k = 1; k <= T_CYC; k++) begin
      tick();
      check("wd_err_early", {31'd0, timeout_err}, 32'd0);
      check("wd_no_frame_done", {31'd0, frame_done}, 32'd0);
    end
    tick();
    check("wd_timeout_err", {31'd0, timeout_err}, 32'd1);
    check("wd_busy", {31'd0, busy}, 32'd0);
    check("wd_no_frame_done", {31'd0, frame_done}, 32'd0);

    // Second timeout with err_clr in the same cycle: set wins.
    req_valid = 4'b0001;
    #1;
    check("wd2_req_ready", {28'd0, req_ready}, 32'd1);
    tick();
    req_valid = 4'b0000;
    repeat (T_CYC) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("wd2_set_wins", {31'd0, timeout_err}, 32'd1);
    check("wd2_busy", {31'd0, busy}, 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", {31'd0, timeout_err}, 32'd0);
    model_en = 1'b1;

    // Reset five cycles after tx_start.
    wait_idle();
    req_valid = 4'b0010;
    #1;
    check("mid_req_ready", {28'd0, req_ready}, 32'd2);
    tick();
    req_valid = 4'b0000;
    check("mid_tx_start", {31'd0, tx_start}, 32'd1);
    repeat (5) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_grant_id", {30'd0, grant_id}, 32'd0);
    check("mid_tx_data", {24'd0, tx_data}, 32'd0);
    for (int k = 0; k < 14; k++) begin
      tick();
      check("mid_no_frame_done", {31'd0, frame_done}, 32'd0);
    end

    // Continuous requests: grants 0,1,2,3,0 every 13 cycles.
    req_valid = 4'b1111;
    #1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      if (req_ready != 4'b0000 && n < 5) begin
        gid[n] = 0;
        for (int j = 0; j < 4; j++) if (req_ready[j]) gid[n] = j;
        gcyc[n] = cyc;
        exp_q.push_back(byte_tab[gid[n]]);
        n++;
      end
      tick();
    end
    req_valid = 4'b0000;
    check("rr_grant_count", n, 5);
    for (int k = 0; k < n; k++) begin
      check("rr_grant", gid[k], k % 4);
      if (k > 0) check("rr_spacing", gcyc[k] - gcyc[k-1], 13);
    end
    wait_idle();
    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one scan-enabled UART transmitter between `NUM_REQ` byte producers. It accepts one byte at a time over per-requester valid/ready handshakes and holds the byte in a register. It pulses `tx_start` into the transmitter, holds `tx_data` stable for the whole frame, and waits for `tx_done` before granting again. A watchdog recovers the arbiter if `tx_done` never arrives. The block sits between the producers and the UART transmitter's functional ports.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `TIMEOUT_CYCLES`, 32: maximum cycles spent in WAIT before a timeout abort; must be ≥ 12.
- `IDW`, $clog2(NUM_REQ): requester index width.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `req_valid` input NUM_REQ: bit i set means requester i offers a byte.
- `req_data` input NUM_REQ*8: byte of requester i in bits [8i+7:8i].
- `req_ready` output NUM_REQ: one-hot (or zero) accept strobe; a byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_start` output 1: one-cycle start pulse to the UART transmitter.
- `tx_data` output 8: held byte; stable from the `tx_start` cycle through the `tx_done` cycle.
- `tx_done` input 1: frame-complete pulse from the UART transmitter.
- `busy` output 1: high whenever the state is not IDLE.
- `grant_id` output IDW: index of the requester whose byte is held or in flight.
- `frame_done` output 1: one-cycle pulse when a frame completes normally.
- `timeout_err` output 1: sticky flag set by a watchdog abort.
- `err_clr` input 1: clears `timeout_err`.

## Operation
- States: IDLE, START, WAIT.
- IDLE, no `req_valid` bit set: remain in IDLE; `req_ready` = 0.
- IDLE, any `req_valid` bit set:
  - Winner is the first set bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - `req_ready[winner]` = 1 combinationally in this cycle only.
  - On the clock edge: hold register <= winner's byte; `grant_id` <= winner; next state START.
- START:
  - `tx_start` = 1 for exactly this cycle.
  - Watchdog counter cleared to 0.
  - Next state WAIT.
- WAIT, `tx_done` = 1: `frame_done` pulses on the next cycle; `last_grant` <= `grant_id`; next state IDLE.
- WAIT, `tx_done` = 0: counter increments.
- WAIT, counter reaches TIMEOUT_CYCLES-1 with `tx_done` = 0:
  - `timeout_err` <= 1; `last_grant` <= `grant_id`; next state IDLE.
  - No `frame_done`. The byte is dropped, not retried.
- `tx_done` in IDLE or START is ignored.
- `req_ready` is 0 in START and WAIT regardless of `req_valid`.
- A requester may drop `req_valid` at any time before acceptance; it is not arbitrated that cycle.
- `err_clr` = 1 clears `timeout_err` on the next edge. If a timeout occurs in the same cycle, set wins.
- Counter width: $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Reset (`reset` = 0 at an edge, including mid-frame):
  - State <= IDLE; `tx_start`, `frame_done`, `timeout_err`, `grant_id`, hold register, counter <= 0.
  - `last_grant` <= NUM_REQ-1, so requester 0 has first priority.
  - Outputs in the first cycle after reset: `busy` = 0, `req_ready` = 0 unless `req_valid` is already set, `tx_data` = 0.
  - The UART transmitter must be reset in the same cycle; the system guarantees this.

## Timing
- Accept edge E. `tx_start` is high in the cycle after E. The transmitter loads `tx_data` one cycle after `tx_start`, so `tx_data` must not change before `tx_done`.
- With the attached transmitter, `tx_done` arrives 11 cycles after `tx_start`: START → shift 8 bits → STOP → DONE.
- The arbiter re-enters IDLE the cycle after `tx_done`, when the transmitter is also idle.
- Back-to-back accept interval: 13 cycles per byte.
- Accept-to-`tx_start` latency: 1 cycle.
- `frame_done` is high in the cycle after `tx_done`.
- `req_ready` is combinational from state, `req_valid` and `last_grant`; it has no dependency on `tx_done`.
- All other outputs are registered.

## Test plan
- Reset and single request:
  - Release `reset`; `req_valid` = 0001, byte 0xA5.
  - Expect `req_ready` = 0001 in that cycle, then `tx_start` 1 cycle later, `tx_data` = 0xA5 held.
  - Expect `tx_done` 11 cycles after `tx_start`; `frame_done` 1 cycle after `tx_done`; `busy` low after that.
- Round robin, all four requesters valid continuously with bytes 0x10/0x21/0x32/0x43:
  - Expect grants 0,1,2,3,0 at 13-cycle spacing.
  - Expect serial `tx_out` to carry each byte LSB-first.
- Skip and wrap:
  - After a grant to requester 2, only requesters 0 and 1 valid.
  - Expect the next grant to be 0, then 1.
- Watchdog:
  - Replace `tx_done` with a constant 0.
  - Expect `timeout_err` = 1 exactly TIMEOUT_CYCLES cycles after WAIT entry, no `frame_done`, return to IDLE.
  - Assert `err_clr` together with a second timeout: expect the flag to stay 1.
- Reset mid-frame:
  - Assert `reset` = 0 for one cycle 5 cycles after `tx_start`.
  - Expect `busy` = 0 and `grant_id` = 0 after the edge; next grant goes to requester 0.
  - Expect no `frame_done` for the aborted byte.
- Spurious `tx_done` in IDLE and in START:
  - Expect no state change and no `frame_done`.
